// File: rtl/decod_scan_n.sv
// decod_scan_n: registered SEL_W-to-2^SEL_W one-hot decoder with an
// auto-scan mode that rotates the active bit with a programmable dwell.
// Optional build macro DECOD_SCAN_ACTIVE_LOW_EN drives `out` active-low
// (inactive value all ones, active bit 0); idx and wrap are unaffected.
module decod_scan_n #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    hold,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(1<<SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);

    localparam int OUT_W = 1 << SEL_W;

`ifdef DECOD_SCAN_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] OUT_INV = '1;
`else
    localparam logic [OUT_W-1:0] OUT_INV = '0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 wrap_q, wrap_d;

    // State and datapath registers, asynchronously cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= OUT_INV;
            idx_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state is re-evaluated every cycle from en and mode alone.
    always_comb begin
        state_d = IDLE;
        if (en) begin
            state_d = mode ? SCAN : DIRECT;
        end
    end

    // Next datapath values; out is always the decode of the next idx.
    // A SCAN cycle following a non-SCAN cycle restarts at position 0.
    always_comb begin
        idx_d  = '0;
        cnt_d  = '0;
        wrap_d = 1'b0;
        unique case (state_d)
            DIRECT: begin
                idx_d = sel;
            end
            SCAN: begin
                if (state_q != SCAN) begin
                    idx_d = '0;
                end else if (hold) begin
                    idx_d = idx_q;
                    cnt_d = cnt_q;
                end else if (cnt_q >= dwell) begin
                    // >= so a dwell lowered below cnt advances at once
                    idx_d  = idx_q + 1'b1;
                    wrap_d = &idx_q;
                end else begin
                    idx_d = idx_q;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase
        if (state_d == IDLE) begin
            out_d = OUT_INV;
        end else begin
            out_d = (OUT_W'(1) << idx_d) ^ OUT_INV;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: doc/decod_scan_n.md
Name: decod_scan_n

Overview:
- Parametrised, registered successor to the team's fixed 3-to-8 gate-level decoder.
- Decodes SEL_W select bits to a 2^SEL_W one-hot output.
- Adds an auto-scan mode that rotates the one-hot bit with a programmable dwell time, for multiplexing 7-segment digits and LED matrices in later projects.
- Sits between the display/control logic and the digit-enable pins.

Parameters:
- SEL_W, 3, select width; output width OUT_W = 2^SEL_W is a derived localparam (8 by default).
- DWELL_W, 16, width of the dwell counter and the dwell input.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  block enable; 0 forces all outputs inactive.
- mode  input  1  0 = direct decode, 1 = auto-scan.
- hold  input  1  in scan mode, freezes the dwell counter and the current position.
- sel  input  SEL_W  select value, used in direct mode.
- dwell  input  DWELL_W  cycles per scan position minus one.
- out  output  OUT_W  one-hot (or all-zero) decoded output, registered.
- idx  output  SEL_W  index of the currently active output bit, registered.
- wrap  output  1  one-cycle pulse when a scan wraps from OUT_W-1 back to 0.

Behaviour:
- Reset (asynchronous, reset=1) values: out=0, idx=0, wrap=0, dwell counter cnt=0, state IDLE.
- States:
  - IDLE: entered when en=0.
  - DIRECT: en=1, mode=0.
  - SCAN: en=1, mode=1.
  - The state is re-evaluated every cycle from en and mode.
- IDLE: next cycle out=0, idx=0, cnt=0, wrap=0.
- DIRECT:
  - out = 1<<sel and idx = sel, one cycle after sel is sampled (latency 1).
  - cnt is held at 0; wrap=0.
- Entering SCAN from IDLE or DIRECT:
  - The first SCAN cycle loads idx=0, out=1 (bit 0), cnt=0.
  - Every entry into SCAN restarts at position 0.
- SCAN, hold=0:
  - If cnt >= dwell: cnt clears to 0 and idx advances to (idx+1) mod OUT_W.
  - Otherwise cnt increments by 1.
  - out always equals 1<<idx, registered together with idx.
- SCAN, hold=1: cnt, idx and out hold their values; wrap=0.
- The >= compare is mandatory. Lowering dwell below the current cnt advances on the next cycle; the counter never runs to wrap-around.
- dwell=0: the position advances every cycle; the full scan period is OUT_W cycles.
- wrap asserts for exactly one cycle, in the same cycle idx becomes 0 from OUT_W-1. It never asserts on entry to SCAN.
- Scan period = OUT_W*(dwell+1) cycles, with dwell held constant and hold=0.
- Mode switch SCAN→DIRECT: the next cycle shows decode(sel); cnt clears.
- en falling at any point: the next cycle gives all outputs 0.
- reset mid-scan: outputs go to reset values immediately, without waiting for a clock edge. On release, the first rising edge applies the normal rules.
- out is never multi-hot. It is either one-hot or all-zero.

Optional Feature:
- Macro: DECOD_SCAN_ACTIVE_LOW_EN.
- Defined:
  - out is driven inverted (active-low), for common-anode digit drivers.
  - Reset and IDLE value of out is all ones.
  - The active bit is 0.
- Undefined: active-high behaviour as described above.
- idx and wrap are unaffected in either case.

Test Plan:
- Reset asserted asynchronously mid-cycle while in SCAN at idx=5 → out=8'h00, idx=0 and wrap=0 immediately. After release with en=0, outputs stay 0.
- DIRECT, en=1, mode=0, sel swept 0..7 one value per cycle → out follows 8'h01,8'h02,…,8'h80, each one cycle after its sel. idx mirrors sel.
- SCAN with dwell=2, hold=0 → each idx held 3 cycles. Sequence 0..7 then back to 0. wrap pulses once, every 24 cycles, coincident with idx=0. out = 1<<idx throughout.
- SCAN with dwell=0 → idx advances every cycle; wrap every 8 cycles. Assert hold=1 at idx=3 for 5 cycles → idx=3, out=8'h08, wrap=0 for all 5. Release → idx=4 on the next cycle.
- SCAN with dwell=10, wait until cnt=7, then set dwell=4 → advance on the next cycle, then 5-cycle dwell per position. Switch mode to 0 with sel=6 → out=8'h40 next cycle. Drop en → out=0 next cycle.
- Build with DECOD_SCAN_ACTIVE_LOW_EN, SEL_W=2:
  - Reset → out=4'hF.
  - DIRECT, sel=2 → out=4'hB.
  - SCAN, dwell=0 → out cycles E,D,B,7, and wrap still pulses active-high.
